// File: rtl/mc_ctrl_hs_pkg.sv
// Shared definitions for the multicycle RV32I control unit: opcodes,
// state encoding and datapath select encodings.
package mc_ctrl_hs_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_DECODE     = 4'd1,
        S_EXEC_R     = 4'd2,
        S_EXEC_I     = 4'd3,
        S_ADDR       = 4'd4,
        S_LOAD_WAIT  = 4'd5,
        S_LOAD_WB    = 4'd6,
        S_STORE_WAIT = 4'd7,
        S_BRANCH     = 4'd8,
        S_JAL        = 4'd9,
        S_JALR       = 4'd10,
        S_TRAP       = 4'd11
    } state_t;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_IMM = 2'b01;
    localparam logic [1:0] PCSRC_ALU = 2'b10;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MDR = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    localparam logic [1:0] ALUB_RS2 = 2'b00;
    localparam logic [1:0] ALUB_IMM = 2'b01;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // States in which the controller waits on a memory handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_LOAD_WAIT) || (s == S_STORE_WAIT);
    endfunction

endpackage

// File: rtl/mc_ctrl_hs_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// datapath controls, trap status and retirement count out.
interface mc_ctrl_hs_if #(parameter int CNT_W = 32);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             zero;
    logic             mem_ready;

    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             PCWrite;
    logic [1:0]       PCSource;
    logic             RegWrite;
    logic [1:0]       MemtoReg;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic             illegal_instr;
    logic             mem_timeout;
    logic             halted;
    logic             retire;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state_out;

    // Datapath side: supplies instruction fields and memory status.
    modport master (
        output opcode, funct3, funct7, zero, mem_ready,
        input  IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource, RegWrite,
               MemtoReg, ALUSrcA, ALUSrcB, ALUOp, illegal_instr, mem_timeout,
               halted, retire, instret, state_out
    );

    // Control unit side.
    modport slave (
        input  opcode, funct3, funct7, zero, mem_ready,
        output IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource, RegWrite,
               MemtoReg, ALUSrcA, ALUSrcB, ALUOp, illegal_instr, mem_timeout,
               halted, retire, instret, state_out
    );

endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags when the
// count reaches the configured limit. A limit of 0 never times out.
module mc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);

    localparam int             CW     = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LIMIT  = CW'(TIMEOUT_CYCLES);
    localparam logic           ENABLE = (TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;

    logic [CW-1:0] r_cnt;

    // Count stalled cycles while waiting; any non-waiting or ready cycle rearms at zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_active && !i_ready) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= {CW{1'b0}};
        end
    end

    // A ready in the limit cycle completes the access, so it masks the timeout.
    assign o_timeout = ENABLE && i_active && !i_ready && (r_cnt == LIMIT);

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle RV32I control unit with mem_ready handshake, wait timeout,
// illegal-instruction trap and retired-instruction counter.
module mc_ctrl_hs
    import mc_ctrl_hs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32
) (
    input  logic         clock,
    input  logic         reset,
    mc_ctrl_hs_if.slave  bus
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic             w_active;
    logic             w_timeout;
    logic             w_retire;

    assign w_active = is_wait_state(r_state);

    mc_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .i_active  (w_active),
        .i_ready   (bus.mem_ready),
        .o_timeout (w_timeout)
    );

    // State register; reset abandons any access in flight and restarts at FETCH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter, wraps naturally at its width.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_instret <= {CNT_W{1'b0}};
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end else begin
            r_instret <= r_instret;
        end
    end

    // Next state and datapath controls; everything idle unless the state asks for it.
    always_comb begin
        w_next            = r_state;
        w_retire          = 1'b0;
        bus.IorD          = 1'b0;
        bus.MemRead       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.PCWrite       = 1'b0;
        bus.PCSource      = PCSRC_PC4;
        bus.RegWrite      = 1'b0;
        bus.MemtoReg      = MTR_ALU;
        bus.ALUSrcA       = 1'b0;
        bus.ALUSrcB       = ALUB_RS2;
        bus.ALUOp         = ALUOP_ADD;
        bus.illegal_instr = 1'b0;
        bus.mem_timeout   = 1'b0;
        bus.halted        = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    w_next      = S_DECODE;
                end else if (w_timeout) begin
                    bus.mem_timeout = 1'b1;
                    w_next          = S_TRAP;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OPC_RTYPE:  w_next = S_EXEC_R;
                    OPC_OPIMM:  w_next = S_EXEC_I;
                    OPC_LOAD:   w_next = S_ADDR;
                    OPC_STORE:  w_next = S_ADDR;
                    OPC_BRANCH: w_next = S_BRANCH;
                    OPC_JAL:    w_next = S_JAL;
                    OPC_JALR:   w_next = S_JALR;
                    default: begin
                        bus.illegal_instr = 1'b1;
                        w_next            = S_TRAP;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                bus.ALUOp    = ALUOP_FUNCT;
                bus.ALUSrcB  = (r_state == S_EXEC_I) ? ALUB_IMM : ALUB_RS2;
                bus.RegWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_ADDR: begin
                bus.ALUSrcB = ALUB_IMM;
                // IR is still latched, so the opcode picks the access direction.
                if (bus.opcode == OPC_LOAD) begin
                    w_next = S_LOAD_WAIT;
                end else begin
                    w_next = S_STORE_WAIT;
                end
            end
            S_LOAD_WAIT: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_LOAD_WB;
                end else if (w_timeout) begin
                    bus.mem_timeout = 1'b1;
                    w_next          = S_TRAP;
                end else begin
                    w_next = S_LOAD_WAIT;
                end
            end
            S_LOAD_WB: begin
                bus.MemtoReg = MTR_MDR;
                bus.RegWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_STORE_WAIT: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                if (bus.mem_ready) begin
                    bus.PCWrite = 1'b1;
                    w_retire    = 1'b1;
                    w_next      = S_FETCH;
                end else if (w_timeout) begin
                    bus.mem_timeout = 1'b1;
                    w_next          = S_TRAP;
                end else begin
                    w_next = S_STORE_WAIT;
                end
            end
            S_BRANCH: begin
                bus.ALUOp = ALUOP_SUB;
                case (bus.funct3)
                    F3_BEQ: begin
                        bus.PCWrite  = 1'b1;
                        bus.PCSource = bus.zero ? PCSRC_IMM : PCSRC_PC4;
                        w_retire     = 1'b1;
                        w_next       = S_FETCH;
                    end
                    F3_BNE: begin
                        bus.PCWrite  = 1'b1;
                        bus.PCSource = bus.zero ? PCSRC_PC4 : PCSRC_IMM;
                        w_retire     = 1'b1;
                        w_next       = S_FETCH;
                    end
                    default: begin
                        bus.illegal_instr = 1'b1;
                        w_next            = S_TRAP;
                    end
                endcase
            end
            S_JAL: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = MTR_PC4;
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_IMM;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_JALR: begin
                bus.ALUSrcB = ALUB_IMM;
                if (bus.funct3 == F3_JALR) begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = MTR_PC4;
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = PCSRC_ALU;
                    w_retire     = 1'b1;
                    w_next       = S_FETCH;
                end else begin
                    bus.illegal_instr = 1'b1;
                    w_next            = S_TRAP;
                end
            end
            S_TRAP: begin
                bus.halted = 1'b1;
                w_next     = S_TRAP;
            end
            default: begin
                // Unused encodings are treated as a fault and parked in TRAP.
                w_next = S_TRAP;
            end
        endcase
    end

    assign bus.retire    = w_retire;
    assign bus.instret   = r_instret;
    assign bus.state_out = r_state;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Self-checking bench: two controllers (long timeout / 4-bit counter and
// short timeout / 32-bit counter) share one stimulus stream and are compared
// every cycle against an instruction-plan reference model.
module tb_mc_ctrl_hs;
    import mc_ctrl_hs_pkg::*;

    localparam int TO_A = 15;
    localparam int W_A  = 4;
    localparam int TO_B = 3;
    localparam int W_B  = 32;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] ir_opc;
    logic [2:0] ir_f3;
    logic [6:0] ir_f7;
    logic       in_zero;
    logic       in_ready;

    always #5 clock = ~clock;

    mc_ctrl_hs_if #(.CNT_W(W_A)) if_a ();
    mc_ctrl_hs_if #(.CNT_W(W_B)) if_b ();

    assign if_a.opcode = ir_opc;  assign if_b.opcode = ir_opc;
    assign if_a.funct3 = ir_f3;   assign if_b.funct3 = ir_f3;
    assign if_a.funct7 = ir_f7;   assign if_b.funct7 = ir_f7;
    assign if_a.zero   = in_zero; assign if_b.zero   = in_zero;
    assign if_a.mem_ready = in_ready; assign if_b.mem_ready = in_ready;

    mc_ctrl_hs #(.TIMEOUT_CYCLES(TO_A), .CNT_W(W_A)) dut_a (.clock(clock), .reset(reset), .bus(if_a.slave));
    mc_ctrl_hs #(.TIMEOUT_CYCLES(TO_B), .CNT_W(W_B)) dut_b (.clock(clock), .reset(reset), .bus(if_b.slave));

    wire [18:0] ctl_a = {if_a.IorD, if_a.MemRead, if_a.MemWrite, if_a.IRWrite, if_a.PCWrite,
                         if_a.PCSource, if_a.RegWrite, if_a.MemtoReg, if_a.ALUSrcA, if_a.ALUSrcB,
                         if_a.ALUOp, if_a.illegal_instr, if_a.mem_timeout, if_a.halted, if_a.retire};
    wire [18:0] ctl_b = {if_b.IorD, if_b.MemRead, if_b.MemWrite, if_b.IRWrite, if_b.PCWrite,
                         if_b.PCSource, if_b.RegWrite, if_b.MemtoReg, if_b.ALUSrcA, if_b.ALUSrcB,
                         if_b.ALUOp, if_b.illegal_instr, if_b.mem_timeout, if_b.halted, if_b.retire};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current step plus the remaining plan of the instruction.
    state_t      m_cur[2];
    state_t      m_plan[2][3];
    int          m_plen[2];
    int          m_ppos[2];
    int          m_wcnt[2];
    logic [31:0] m_instret[2];
    int          m_to[2];
    logic [31:0] m_mask[2];

    // Observations from the last checked cycle (used by directed scenarios).
    logic       obs_retire_a, obs_ill_a, obs_to_b, obs_memrd_a;
    logic [1:0] obs_pcs_a;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic waits_on_mem(input state_t s);
        return (s == S_FETCH) || (s == S_LOAD_WAIT) || (s == S_STORE_WAIT);
    endfunction

    task automatic model_reset_all();
        for (int i = 0; i < 2; i++) begin
            m_cur[i] = S_FETCH; m_plen[i] = 0; m_ppos[i] = 0; m_wcnt[i] = 0; m_instret[i] = 32'd0;
        end
        m_to[0] = TO_A; m_to[1] = TO_B;
        m_mask[0] = 32'h0000_000F; m_mask[1] = 32'hFFFF_FFFF;
    endtask

    // One cycle of instance i: returns expected outputs for this cycle, then advances.
    task automatic model_cycle(input int i, input logic rst_n, input logic mr, input logic z,
                               output logic [18:0] ctl, output logic [3:0] st, output logic [31:0] cnt);
        logic iord, mrd, mwr, irw, pcw, rw, ill, tmo, hlt, ret, done, taken;
        logic [1:0] pcs, mtr, asb, aop;
        state_t cur, nxt;
        cur = m_cur[i];
        {iord, mrd, mwr, irw, pcw, rw, ill, tmo, hlt, ret, done, taken} = 12'd0;
        pcs = 2'b00; mtr = 2'b00; asb = 2'b00; aop = 2'b00;
        nxt = cur;
        st  = cur;
        cnt = m_instret[i];
        case (cur)
            S_FETCH: begin
                mrd = 1'b1;
                if (mr) begin irw = 1'b1; nxt = S_DECODE; end
            end
            S_DECODE: begin
                m_plen[i] = 1; m_ppos[i] = 0; done = 1'b1;
                case (ir_opc)
                    OPC_RTYPE:  m_plan[i][0] = S_EXEC_R;
                    OPC_OPIMM:  m_plan[i][0] = S_EXEC_I;
                    OPC_BRANCH: m_plan[i][0] = S_BRANCH;
                    OPC_JAL:    m_plan[i][0] = S_JAL;
                    OPC_JALR:   m_plan[i][0] = S_JALR;
                    OPC_LOAD: begin
                        m_plan[i][0] = S_ADDR; m_plan[i][1] = S_LOAD_WAIT; m_plan[i][2] = S_LOAD_WB;
                        m_plen[i] = 3;
                    end
                    OPC_STORE: begin
                        m_plan[i][0] = S_ADDR; m_plan[i][1] = S_STORE_WAIT; m_plen[i] = 2;
                    end
                    default: begin ill = 1'b1; done = 1'b0; nxt = S_TRAP; end
                endcase
            end
            S_EXEC_R: begin aop = 2'b10; rw = 1'b1; pcw = 1'b1; ret = 1'b1; done = 1'b1; end
            S_EXEC_I: begin aop = 2'b10; asb = 2'b01; rw = 1'b1; pcw = 1'b1; ret = 1'b1; done = 1'b1; end
            S_ADDR:   begin asb = 2'b01; done = 1'b1; end
            S_LOAD_WAIT: begin iord = 1'b1; mrd = 1'b1; done = mr; end
            S_LOAD_WB: begin mtr = 2'b01; rw = 1'b1; pcw = 1'b1; ret = 1'b1; done = 1'b1; end
            S_STORE_WAIT: begin
                iord = 1'b1; mwr = 1'b1;
                if (mr) begin pcw = 1'b1; ret = 1'b1; done = 1'b1; end
            end
            S_BRANCH: begin
                aop = 2'b01;
                if (ir_f3 == 3'd0 || ir_f3 == 3'd1) begin
                    taken = (ir_f3 == 3'd0) ? z : !z;
                    pcw = 1'b1; pcs = taken ? 2'b01 : 2'b00; ret = 1'b1; done = 1'b1;
                end else begin
                    ill = 1'b1; nxt = S_TRAP;
                end
            end
            S_JAL: begin rw = 1'b1; mtr = 2'b10; pcw = 1'b1; pcs = 2'b01; ret = 1'b1; done = 1'b1; end
            S_JALR: begin
                asb = 2'b01;
                if (ir_f3 == 3'd0) begin
                    rw = 1'b1; mtr = 2'b10; pcw = 1'b1; pcs = 2'b10; ret = 1'b1; done = 1'b1;
                end else begin
                    ill = 1'b1; nxt = S_TRAP;
                end
            end
            default: hlt = 1'b1;
        endcase
        if (waits_on_mem(cur) && !mr) begin
            if (m_to[i] != 0 && m_wcnt[i] == m_to[i]) begin
                tmo = 1'b1; nxt = S_TRAP;
            end else begin
                m_wcnt[i]++;
            end
        end
        if (done) begin
            if (m_ppos[i] < m_plen[i]) begin
                nxt = m_plan[i][m_ppos[i]];
                m_ppos[i]++;
            end else begin
                nxt = S_FETCH;
            end
        end
        ctl = {iord, mrd, mwr, irw, pcw, pcs, rw, mtr, 1'b0, asb, aop, ill, tmo, hlt, ret};
        if (!rst_n) begin
            nxt = S_FETCH; m_instret[i] = 32'd0; m_wcnt[i] = 0;
        end else begin
            if (ret) m_instret[i] = (m_instret[i] + 32'd1) & m_mask[i];
            if (nxt != cur && waits_on_mem(nxt)) m_wcnt[i] = 0;
        end
        m_cur[i] = nxt;
    endtask

    // Drive one cycle, compare both DUTs to the model before the rising edge.
    task automatic tick(input logic rst_n, input logic mr, input logic z);
        logic [18:0] ec;
        logic [3:0]  es;
        logic [31:0] en;
        reset = rst_n; in_ready = mr; in_zero = z;
        @(negedge clock);
        obs_retire_a = if_a.retire; obs_ill_a = if_a.illegal_instr; obs_to_b = if_b.mem_timeout;
        obs_memrd_a = if_a.MemRead & if_a.IorD; obs_pcs_a = if_a.PCSource;
        model_cycle(0, rst_n, mr, z, ec, es, en);
        check_eq("ctl_a", 32'(ctl_a), 32'(ec));
        check_eq("state_a", 32'(if_a.state_out), 32'(es));
        check_eq("instret_a", 32'(if_a.instret), en);
        model_cycle(1, rst_n, mr, z, ec, es, en);
        check_eq("ctl_b", 32'(ctl_b), 32'(ec));
        check_eq("state_b", 32'(if_b.state_out), 32'(es));
        check_eq("instret_b", if_b.instret, en);
        @(posedge clock);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3);
        ir_opc = opc; ir_f3 = f3; ir_f7 = 7'd0;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0);
        check_eq("rst_state", 32'(if_a.state_out), 32'(S_FETCH));
        check_eq("rst_memread", 32'(if_a.MemRead), 32'd1);
        check_eq("rst_halted", 32'(if_b.halted), 32'd0);
    endtask

    // Run one instruction on instance a, delaying each fetch/data ready.
    task automatic run_instr(input int fdel, input int ddel, input logic z,
                             output int cycles, output int memcyc);
        state_t prev, cur;
        int     wcyc;
        logic   mr, fin;
        prev = S_TRAP; wcyc = 0; cycles = 0; memcyc = 0; fin = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            cur = m_cur[0];
            if (cur != prev) wcyc = 0;
            if (cur == S_FETCH)                                mr = (wcyc >= fdel);
            else if (cur == S_LOAD_WAIT || cur == S_STORE_WAIT) mr = (wcyc >= ddel);
            else                                               mr = 1'($urandom_range(0, 1));
            tick(1'b1, mr, z);
            cycles++;
            if (obs_memrd_a) memcyc++;
            wcyc++;
            prev = cur;
            fin = obs_retire_a || (m_cur[0] == S_TRAP);
        end
        check_eq("run_done", 32'(fin), 32'd1);
    endtask

    task automatic rand_instr();
        int k;
        k = $urandom_range(0, 8);
        ir_f3 = 3'($urandom_range(0, 7));
        ir_f7 = 7'($urandom_range(0, 127));
        case (k)
            0: ir_opc = OPC_RTYPE;
            1: ir_opc = OPC_OPIMM;
            2: ir_opc = OPC_LOAD;
            3: ir_opc = OPC_STORE;
            4, 5: begin
                ir_opc = OPC_BRANCH;
                if ($urandom_range(0, 3) != 0) ir_f3 = 3'($urandom_range(0, 1));
            end
            6: ir_opc = OPC_JAL;
            7: begin
                ir_opc = OPC_JALR;
                if ($urandom_range(0, 3) != 0) ir_f3 = 3'd0;
            end
            default: ir_opc = 7'b1110011;
        endcase
    endtask

    initial begin
        int cyc, mc, stall, trap_a, trap_b;
        logic mr, rn;
        model_reset_all();
        set_instr(OPC_RTYPE, 3'd0);
        do_reset();
        do_reset();

        // add, ready tied high: 3 cycles, instret 0 -> 1
        set_instr(OPC_RTYPE, 3'd0);
        run_instr(0, 0, 1'b0, cyc, mc);
        check_eq("add_cycles", 32'(cyc), 32'd3);
        check_eq("add_instret", 32'(if_a.instret), 32'd1);

        // lw with data ready 4 cycles late: 9 cycles, 5 cycles of data read
        set_instr(OPC_LOAD, 3'd2);
        run_instr(0, 4, 1'b0, cyc, mc);
        check_eq("lw_cycles", 32'(cyc), 32'd9);
        check_eq("lw_memcycles", 32'(mc), 32'd5);
        check_eq("lw_instret", 32'(if_a.instret), 32'd2);
        check_eq("lw_b_trapped", 32'(if_b.halted), 32'd1);
        do_reset();

        // branches: beq/bne with zero set and clear
        set_instr(OPC_BRANCH, F3_BEQ); run_instr(0, 0, 1'b1, cyc, mc);
        check_eq("beq_z1_pcs", 32'(obs_pcs_a), 32'd1);
        set_instr(OPC_BRANCH, F3_BEQ); run_instr(0, 0, 1'b0, cyc, mc);
        check_eq("beq_z0_pcs", 32'(obs_pcs_a), 32'd0);
        set_instr(OPC_BRANCH, F3_BNE); run_instr(0, 0, 1'b1, cyc, mc);
        check_eq("bne_z1_pcs", 32'(obs_pcs_a), 32'd0);
        set_instr(OPC_BRANCH, F3_BNE); run_instr(0, 0, 1'b0, cyc, mc);
        check_eq("bne_z0_pcs", 32'(obs_pcs_a), 32'd1);
        check_eq("br_cycles", 32'(cyc), 32'd3);
        set_instr(OPC_BRANCH, 3'b010); run_instr(0, 0, 1'b0, cyc, mc);
        check_eq("br_ill_pulse", 32'(obs_ill_a), 32'd1);
        check_eq("br_ill_halted", 32'(if_a.halted), 32'd1);
        tick(1'b1, 1'b1, 1'b0);
        check_eq("trap_sticky", 32'(if_a.state_out), 32'(S_TRAP));

        // fetch timeout with limit 3 on instance b
        set_instr(OPC_RTYPE, 3'd0);
        do_reset();
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0);
        check_eq("to_early", 32'(obs_to_b), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        check_eq("to_pulse", 32'(obs_to_b), 32'd1);
        check_eq("to_halted", 32'(if_b.halted), 32'd1);
        do_reset();
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check_eq("to_ready_wins", 32'(obs_to_b), 32'd0);
        check_eq("to_ready_state", 32'(if_b.state_out), 32'(S_DECODE));

        // reset in the middle of a store
        do_reset();
        set_instr(OPC_STORE, 3'd2);
        for (int k = 0; k < 10 && m_cur[0] != S_STORE_WAIT; k++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("rst_store_memwrite", 32'(if_a.MemWrite), 32'd0);
        check_eq("rst_store_state", 32'(if_a.state_out), 32'(S_FETCH));
        check_eq("rst_store_instret", 32'(if_a.instret), 32'd0);

        // 4-bit counter wraps after 16 retirements
        set_instr(OPC_RTYPE, 3'd0);
        for (int k = 0; k < 16; k++) begin
            run_instr(0, 0, 1'b0, cyc, mc);
            if (k == 14) check_eq("wrap_15", 32'(if_a.instret), 32'd15);
        end
        check_eq("wrap_zero", 32'(if_a.instret), 32'd0);
        check_eq("wrap_b16", if_b.instret, 32'd16);

        // randomized traffic
        stall = 0; trap_a = 0; trap_b = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_cur[0] == S_FETCH || m_cur[0] == S_TRAP) rand_instr();
            if (stall > 0) begin
                mr = 1'b0; stall--;
            end else if ($urandom_range(0, 299) == 0) begin
                mr = 1'b0; stall = 20;
            end else begin
                mr = ($urandom_range(0, 9) < 7);
            end
            trap_a = (m_cur[0] == S_TRAP) ? trap_a + 1 : 0;
            trap_b = (m_cur[1] == S_TRAP) ? trap_b + 1 : 0;
            rn = !(trap_a >= 3 || trap_b >= 25 || $urandom_range(0, 149) == 0);
            tick(rn, mr, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

endmodule
